// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, DONE
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam logic DEV_ROM = 1'b0;
  localparam logic DEV_RAM = 1'b1;

  localparam int unsigned CNT_W = 6;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI mode-0 clock divider: sclk idles low, toggles every CLK_DIV clocks while en,
// with combinational strobes marking the system edge on which sclk will rise/fall.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt;
  logic          tick_c;

  assign tick_c = en && (cnt == DW'(CLK_DIV - 1));
  assign rise_c = tick_c && !sclk;
  assign fall_c = tick_c && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick_c) begin
      cnt  <= '0;
      sclk <= !sclk;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI master for program ROM / data RAM behind a 4-phase start/done handshake.
// Build option: define SPI_FAST_READ_EN for ROM fast-read (0x0B + 8 dummy clocks).
module spi_mem_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned ADDR_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dev,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_rom_n,
  output logic        cs_ram_n
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t             state, state_d;
  logic [DW-1:0]      dly_q, dly_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic               dev_q, dev_d, wr_q, wr_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d, rx_q, rx_d, rdata_d;
  logic               done_d, busy_d, mosi_d, cs_rom_n_d, cs_ram_n_d;
  logic               en_c, rise_c, fall_c, dly_end_c, last_c, fast_c, cs_act_c;
  logic [7:0]         cmd_c, cmd_sh_c, data_sh_c;
  logic [ADDR_W-1:0]  addr_sh_c;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (en_c),
    .sclk   (sclk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign en_c      = state inside {CMD, ADDR, DUMMY, DATA};
  assign dly_end_c = (dly_q == DW'(CLK_DIV - 1));
  assign last_c    = (bit_q == '0);

`ifdef SPI_FAST_READ_EN
  assign fast_c = (dev_q == DEV_ROM) && !wr_q;
`else
  assign fast_c = 1'b0;
`endif

  assign cmd_c = wr_q ? CMD_WRITE : (fast_c ? CMD_FAST_READ : CMD_READ);

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d = state;
    dly_d   = dly_q;
    bit_d   = bit_q;
    dev_d   = dev_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rx_d    = rx_q;
    rdata_d = rdata;
    done_d  = done;
    busy_d  = busy;

    unique case (state)
      IDLE: begin
        if (start && !done) begin
          dev_d   = dev;
          wr_d    = wr;
          addr_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
          dly_d   = '0;
          state_d = (wr && dev == DEV_ROM) ? DONE : CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (dly_end_c) begin
          state_d = CMD;
          bit_d   = CNT_W'(7);
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      CMD: begin
        if (fall_c) begin
          if (last_c) begin
            state_d = ADDR;
            bit_d   = CNT_W'(ADDR_W - 1);
          end else begin
            bit_d = bit_q - CNT_W'(1);
          end
        end
      end
      ADDR: begin
        if (fall_c) begin
          if (last_c) begin
            state_d = fast_c ? DUMMY : DATA;
            bit_d   = CNT_W'(7);
          end else begin
            bit_d = bit_q - CNT_W'(1);
          end
        end
      end
      DUMMY: begin
        if (fall_c) begin
          if (last_c) begin
            state_d = DATA;
            bit_d   = CNT_W'(7);
          end else begin
            bit_d = bit_q - CNT_W'(1);
          end
        end
      end
      DATA: begin
        // rdata only moves once the full byte is in
        if (rise_c) begin
          rx_d = {rx_q[6:0], miso};
          if (last_c && !wr_q) rdata_d = rx_d;
        end
        if (fall_c) begin
          if (last_c) begin
            state_d = CS_HOLD;
            dly_d   = '0;
          end else begin
            bit_d = bit_q - CNT_W'(1);
          end
        end
      end
      CS_HOLD: begin
        if (dly_end_c) state_d = DONE;
        else           dly_d   = dly_q + DW'(1);
      end
      DONE: begin
        // first DONE cycle always raises done, so an early start drop still yields a pulse
        if (!done) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cs_act_c   = state_d inside {CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD};
    cs_rom_n_d = !(cs_act_c && dev_d == DEV_ROM);
    cs_ram_n_d = !(cs_act_c && dev_d == DEV_RAM);

    cmd_sh_c  = cmd_c >> bit_d;
    addr_sh_c = ADDR_W'(addr_q) >> bit_d;
    data_sh_c = wdata_q >> bit_d;

    mosi_d = 1'b0;
    unique case (state_d)
      CMD:     mosi_d = cmd_sh_c[0];
      ADDR:    mosi_d = addr_sh_c[0];
      DATA:    mosi_d = wr_q & data_sh_c[0];
      default: mosi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dly_q    <= '0;
      bit_q    <= '0;
      dev_q    <= DEV_ROM;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rx_q     <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      mosi     <= 1'b0;
      cs_rom_n <= 1'b1;
      cs_ram_n <= 1'b1;
    end else begin
      state    <= state_d;
      dly_q    <= dly_d;
      bit_q    <= bit_d;
      dev_q    <= dev_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rx_q     <= rx_d;
      rdata    <= rdata_d;
      done     <= done_d;
      busy     <= busy_d;
      mosi     <= mosi_d;
      cs_rom_n <= cs_rom_n_d;
      cs_ram_n <= cs_ram_n_d;
    end
  end

endmodule
